// File: rtl/processador_gen.sv
// processador_gen: multicycle accumulator CPU, FETCH/DECODE/EXEC(/MEM).
// Define PROCESSADOR_GEN_BRANCH_EN to enable the JZ conditional branch.
module processador_gen #(
  parameter int DATA_W  = 8,
  parameter int NREGS   = 4,
  parameter int PROG_AW = 8,
  parameter int DMEM_AW = 8
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PROG_AW-1:0] prom_addr,
  input  logic [15:0]        prom_data,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  output logic               dmem_we,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic [DATA_W-1:0]  stdin,
  output logic [DATA_W-1:0]  stdout,
  output logic               out_valid,
  output logic [1:0]         flags,
  output logic               halted
);

  localparam int RI = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [4:0] NR5 = 5'(NREGS);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_NOT   = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_CLEAR = 4'd7;
  localparam logic [3:0] OP_MOVI  = 4'd8;
  localparam logic [3:0] OP_LOAD  = 4'd9;
  localparam logic [3:0] OP_STORE = 4'd10;
  localparam logic [3:0] OP_OUT   = 4'd11;
  localparam logic [3:0] OP_IN    = 4'd12;
  localparam logic [3:0] OP_JMP   = 4'd13;
  localparam logic [3:0] OP_JZ    = 4'd14;
  localparam logic [3:0] OP_HALT  = 4'd15;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [PROG_AW-1:0] r_pc;
  logic [15:0]        r_ir;
  logic [DATA_W-1:0]  r_regs [NREGS];
  logic               r_carry;
  logic               r_zero;
  logic [DATA_W-1:0]  r_stdout;
  logic               r_out_valid;

  logic [3:0]        w_op;
  logic [3:0]        w_r;
  logic [7:0]        w_imm;
  logic [DATA_W-1:0] w_imm_ext;
  logic              w_r_ok;
  logic [DATA_W-1:0] w_acc;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_alu;
  logic              w_alu_c;
  logic              w_alu_en;
  logic              w_rf_we;
  logic [RI-1:0]     w_rf_idx;
  logic [DATA_W-1:0] w_rf_wdata;
  logic              w_exec;
  logic              w_jump;

  assign w_op      = r_ir[15:12];
  assign w_r       = r_ir[11:8];
  assign w_imm     = r_ir[7:0];
  assign w_imm_ext = DATA_W'(w_imm);
  assign w_exec    = (r_state == S_EXEC);

  // Out-of-range register selects read as zero
  assign w_r_ok  = ({1'b0, w_r} < NR5);
  assign w_rdata = w_r_ok ? r_regs[w_r[RI-1:0]] : '0;
  assign w_acc   = r_regs[0];

  assign w_sum  = {1'b0, w_acc} + {1'b0, w_rdata};
  assign w_diff = {1'b0, w_acc} - {1'b0, w_rdata};

  always_comb begin
    w_alu    = '0;
    w_alu_c  = 1'b0;
    w_alu_en = 1'b0;
    unique case (w_op)
      OP_ADD: begin
        w_alu    = w_sum[DATA_W-1:0];
        w_alu_c  = w_sum[DATA_W];
        w_alu_en = 1'b1;
      end
      OP_SUB: begin
        w_alu    = w_diff[DATA_W-1:0];
        w_alu_c  = w_diff[DATA_W];
        w_alu_en = 1'b1;
      end
      OP_AND: begin
        w_alu    = w_acc & w_rdata;
        w_alu_en = 1'b1;
      end
      OP_OR: begin
        w_alu    = w_acc | w_rdata;
        w_alu_en = 1'b1;
      end
      OP_NOT: begin
        w_alu    = ~w_rdata;
        w_alu_en = 1'b1;
      end
      OP_XOR: begin
        w_alu    = w_acc ^ w_rdata;
        w_alu_en = 1'b1;
      end
      default: begin
        w_alu_en = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_idx   = w_r[RI-1:0];
    w_rf_wdata = '0;
    if (r_state == S_MEM) begin
      w_rf_we    = w_r_ok;
      w_rf_wdata = dmem_rdata;
    end else if (w_exec) begin
      if (w_alu_en) begin
        w_rf_we    = 1'b1;
        w_rf_idx   = '0;
        w_rf_wdata = w_alu;
      end else begin
        unique case (w_op)
          OP_CLEAR: begin
            w_rf_we = w_r_ok;
          end
          OP_MOVI: begin
            w_rf_we    = w_r_ok;
            w_rf_wdata = w_imm_ext;
          end
          OP_IN: begin
            w_rf_we    = w_r_ok;
            w_rf_wdata = stdin;
          end
          default: begin
            w_rf_we = 1'b0;
          end
        endcase
      end
    end
  end

`ifdef PROCESSADOR_GEN_BRANCH_EN
  assign w_jump = (w_op == OP_JMP) ||
                  ((w_op == OP_JZ) && r_zero);
`else
  assign w_jump = (w_op == OP_JMP);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        if (w_op == OP_LOAD) begin
          w_next = S_MEM;
        end else if (w_op == OP_HALT) begin
          w_next = S_HALT;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_MEM:    w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_rf_we) begin
      r_regs[w_rf_idx] <= w_rf_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc        <= '0;
      r_ir        <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_stdout    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (r_state == S_DECODE) begin
        r_ir <= prom_data;
      end
      if (w_exec) begin
        if (w_jump) begin
          r_pc <= w_imm[PROG_AW-1:0];
        end else if (w_op != OP_HALT) begin
          r_pc <= r_pc + PROG_AW'(1);
        end
        if (w_alu_en) begin
          r_carry <= w_alu_c;
          r_zero  <= (w_alu == '0);
        end
        if (w_op == OP_OUT) begin
          r_stdout    <= w_rdata;
          r_out_valid <= 1'b1;
        end
      end
    end
  end

  // Strobe is decoded from state so reset drops it asynchronously
  assign dmem_we    = w_exec && (w_op == OP_STORE);
  assign dmem_addr  = w_imm[DMEM_AW-1:0];
  assign dmem_wdata = w_rdata;
  assign prom_addr  = r_pc;
  assign stdout     = r_stdout;
  assign out_valid  = r_out_valid;
  assign flags      = {r_carry, r_zero};
  assign halted     = (r_state == S_HALT);

endmodule

// File: tb/tb_processador_gen.sv
// tb_processador_gen: directed + random programs vs instruction-level model.
// Honours PROCESSADOR_GEN_BRANCH_EN for the JZ expectation.
module tb_processador_gen;

  localparam int DW  = 8;
  localparam int NR  = 4;
  localparam int PAW = 8;
  localparam int DAW = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [PAW-1:0] prom_addr;
  logic [15:0]    prom_data;
  logic [DAW-1:0] dmem_addr;
  logic [DW-1:0]  dmem_wdata;
  logic           dmem_we;
  logic [DW-1:0]  dmem_rdata;
  logic [DW-1:0]  stdin;
  logic [DW-1:0]  stdout;
  logic           out_valid;
  logic [1:0]     flags;
  logic           halted;

  processador_gen #(
    .DATA_W (DW),
    .NREGS  (NR),
    .PROG_AW(PAW),
    .DMEM_AW(DAW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .prom_addr (prom_addr),
    .prom_data (prom_data),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_we   (dmem_we),
    .dmem_rdata(dmem_rdata),
    .stdin     (stdin),
    .stdout    (stdout),
    .out_valid (out_valid),
    .flags     (flags),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [256];
  logic [7:0]  ram [256];
  int          n_we;
  int          n_ov;

  always @(posedge clk) prom_data <= rom[prom_addr];

  always @(posedge clk) begin
    if (dmem_we) begin
      ram[dmem_addr] <= dmem_wdata;
      n_we <= n_we + 1;
    end
    if (out_valid) n_ov <= n_ov + 1;
    dmem_rdata <= ram[dmem_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  // Architectural model state
  int         mpc;
  logic [7:0] mreg [NR];
  logic       mc;
  logic       mz;
  logic [7:0] mram [256];
  logic [7:0] mout;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rd(input int r);
    return (r < NR) ? int'(mreg[r]) : 0;
  endfunction

  task automatic wr(input int r, input int v);
    if (r < NR) mreg[r] = 8'(v);
  endtask

  task automatic model_reset();
    mpc = 0;
    for (int i = 0; i < NR; i++) mreg[i] = 8'h00;
    mc   = 1'b0;
    mz   = 1'b0;
    mout = 8'h00;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pc", prom_addr, 0);
    chk("rst_flags", flags, 0);
    chk("rst_stdout", stdout, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_halted", halted, 0);
    model_reset();
    rst = 1'b1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  // Entered and left on a negedge inside FETCH
  task automatic run_instr(output bit hlt);
    logic [15:0] ins;
    int op, r, imm, a, b, res, sv;
    bit outp, jmp;
    hlt  = 1'b0;
    outp = 1'b0;
    jmp  = 1'b0;
    chk("fetch_pc", prom_addr, mpc);
    chk("fetch_halted", halted, 0);
    chk("fetch_we", dmem_we, 0);
    ins = rom[mpc];
    op  = int'(ins[15:12]);
    r   = int'(ins[11:8]);
    imm = int'(ins[7:0]);
    sv  = int'($urandom_range(0, 255));
    stdin = 8'(sv);
    @(negedge clk);
    chk("dec_we", dmem_we, 0);
    @(negedge clk);
    a = int'(mreg[0]);
    b = rd(r);
    chk("exec_we", dmem_we, (op == 10) ? 1 : 0);
    if (op == 9 || op == 10) chk("exec_addr", dmem_addr, imm);
    if (op == 10) chk("exec_wdata", dmem_wdata, b);
    res = 0;
    case (op)
      1: begin
        res = a + b;
        mc  = (res > 255);
        res = res % 256;
      end
      2: begin
        mc  = (a < b);
        res = (a - b + 256) % 256;
      end
      3: res = a & b;
      4: res = a | b;
      5: res = (~b) & 255;
      6: res = a ^ b;
      7: wr(r, 0);
      8: wr(r, imm);
      9: wr(r, int'(mram[imm]));
      10: mram[imm] = 8'(b);
      11: begin
        mout = 8'(b);
        outp = 1'b1;
      end
      12: wr(r, sv);
      13: jmp = 1'b1;
`ifdef PROCESSADOR_GEN_BRANCH_EN
      14: jmp = mz;
`endif
      15: hlt = 1'b1;
      default: ;
    endcase
    if (op >= 1 && op <= 6) begin
      mreg[0] = 8'(res);
      mz = (res == 0);
      if (op >= 3) mc = 1'b0;
    end
    if (jmp) mpc = imm;
    else if (!hlt) mpc = (mpc + 1) % 256;
    if (op == 9) begin
      @(negedge clk);
      chk("mem_we", dmem_we, 0);
      chk("mem_ov", out_valid, 0);
    end
    @(negedge clk);
    chk("post_ov", out_valid, outp);
    chk("post_stdout", stdout, mout);
    chk("post_flags", flags, {mc, mz});
    if (hlt) begin
      chk("post_halted", halted, 1);
      chk("post_halt_pc", prom_addr, mpc);
    end
  endtask

  task automatic run_n(input int n);
    bit h;
    for (int i = 0; i < n; i++) run_instr(h);
  endtask

  task automatic check_frozen(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("frz_pc", prom_addr, mpc);
      chk("frz_halted", halted, 1);
      chk("frz_we", dmem_we, 0);
      chk("frz_ov", out_valid, 0);
      chk("frz_flags", flags, {mc, mz});
    end
  endtask

  initial begin
    bit h;
    int v;
    rst   = 1'b0;
    stdin = '0;
    n_we  = 0;
    n_ov  = 0;
    for (int i = 0; i < 256; i++) begin
      v = int'($urandom_range(0, 255));
      ram[i]  = 8'(v);
      mram[i] = 8'(v);
    end

    // ADD with carry out
    clear_rom();
    rom[0] = 16'h81F0;
    rom[1] = 16'h8020;
    rom[2] = 16'h1100;
    rom[3] = 16'hB000;
    reset_dut();
    run_n(3);
    chk("add_flags", flags, 2'b10);
    run_n(1);
    chk("add_acc", stdout, 8'h10);

    // SUB to zero then JZ
    clear_rom();
    rom[0] = 16'h8005;
    rom[1] = 16'h8205;
    rom[2] = 16'h2200;
    rom[3] = 16'hE020;
    reset_dut();
    run_n(3);
    chk("sub_flags", flags, 2'b01);
    run_n(1);
`ifdef PROCESSADOR_GEN_BRANCH_EN
    chk("jz_next", prom_addr, 8'h20);
`else
    chk("jz_next", prom_addr, 8'h04);
`endif

    // STORE / LOAD / OUT round trip
    clear_rom();
    rom[0] = 16'h83AB;
    rom[1] = 16'hA307;
    rom[2] = 16'h9107;
    rom[3] = 16'hB100;
    rom[4] = 16'h0000;
    reset_dut();
    n_we = 0;
    n_ov = 0;
    run_n(5);
    chk("st_pulses", n_we, 1);
    chk("st_ram", ram[7], 8'hAB);
    chk("ld_out", stdout, 8'hAB);
    chk("ov_pulses", n_ov, 1);

    // Out-of-range register, then HALT
    clear_rom();
    rom[0] = 16'h8177;
    rom[1] = 16'hB100;
    rom[2] = 16'h8533;
    rom[3] = 16'hB500;
    rom[4] = 16'hB100;
    rom[5] = 16'hF000;
    reset_dut();
    run_n(2);
    chk("oor_pre", stdout, 8'h77);
    run_n(2);
    chk("oor_out", stdout, 8'h00);
    run_n(1);
    chk("oor_r1", stdout, 8'h77);
    run_instr(h);
    chk("halt_seen", h, 1);
    check_frozen(20);

    // Reset during the MEM cycle of a LOAD
    clear_rom();
    rom[0] = 16'h9107;
    ram[7]  = 8'h5A;
    mram[7] = 8'h5A;
    reset_dut();
    @(negedge clk);
    @(negedge clk);
    chk("ld_exec_we", dmem_we, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_we", dmem_we, 0);
    chk("abort_pc", prom_addr, 0);
    rom[0] = 16'hB100;
    rom[1] = 16'hF000;
    reset_dut();
    run_n(1);
    chk("abort_r1", stdout, 8'h00);
    run_instr(h);
    check_frozen(3);

    // PC wrap over a NOP-only program
    clear_rom();
    reset_dut();
    run_n(256);
    chk("pc_wrap", prom_addr, 0);
    run_n(2);

    // Random programs (no HALT)
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 256; i++) begin
        v = int'($urandom_range(0, 65535));
        if (v[15:12] == 4'hF) v = v & 16'h0FFF;
        rom[i] = 16'(v);
      end
      reset_dut();
      run_n(150);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/processador_gen.md
PROCESSADOR_GEN -- requirements
Module: processador_gen

Interface
REQ-001 Parameter DATA_W, default 8: datapath width, legal range 8..16.
REQ-002 Parameter NREGS, default 4: register-file depth, legal range 2..16; R0 is the accumulator.
REQ-003 Parameter PROG_AW, default 8: PC / program-address width, legal range 4..8.
REQ-004 Parameter DMEM_AW, default 8: data-memory address width, legal range 4..8.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 prom_addr  out  PROG_AW  program ROM address; ROM read data is valid one cycle later.
REQ-008 prom_data  in  16  instruction: op[15:12], r[11:8], imm[7:0].
REQ-009 dmem_addr  out  DMEM_AW  data RAM address.
REQ-010 dmem_wdata  out  DATA_W  data RAM write data.
REQ-011 dmem_we  out  1  data RAM write enable, one-cycle pulse.
REQ-012 dmem_rdata  in  DATA_W  data RAM read data, valid one cycle after the address is presented.
REQ-013 stdin  in  DATA_W  switch input.
REQ-014 stdout  out  DATA_W  registered output port.
REQ-015 out_valid  out  1  one-cycle pulse when stdout is updated.
REQ-016 flags  out  2  {carry, zero}.
REQ-017 halted  out  1  high while in HALT.

Function
REQ-018 The FSM SHALL implement FETCH -> DECODE -> EXEC -> FETCH; LOAD goes EXEC -> MEM -> FETCH; HALT is terminal until reset.
REQ-019 FETCH drives prom_addr=PC; DECODE latches prom_data into IR; EXEC executes IR. Non-LOAD latency is 3 cycles; LOAD latency is 4 cycles.
REQ-020 imm SHALL be zero-extended to DATA_W; jump targets are imm[PROG_AW-1:0]; memory addresses are imm[DMEM_AW-1:0].
REQ-021 If r >= NREGS, reads SHALL return 0 and writes SHALL be discarded.
REQ-022 Opcodes: 0 NOP; 1 ADD ACC<=ACC+R[r]; 2 SUB ACC<=ACC-R[r]; 3 AND; 4 OR; 5 NOT ACC<=~R[r]; 6 XOR; 7 CLEAR R[r]<=0; 8 MOVI R[r]<=imm; 9 LOAD R[r]<=mem[imm]; 10 STORE mem[imm]<=R[r]; 11 OUT stdout<=R[r]; 12 IN R[r]<=stdin; 13 JMP; 14 JZ; 15 HALT.
REQ-023 Opcodes 1..6 SHALL update zero (result==0). ADD sets carry to bit DATA_W of the sum. SUB sets carry to 1 on borrow, and stores the result modulo 2^DATA_W. Opcodes 3..6 clear carry. No other opcode touches the flags.
REQ-024 STORE SHALL assert dmem_we for exactly the EXEC cycle, with dmem_addr and dmem_wdata valid in that same cycle.
REQ-025 LOAD SHALL present dmem_addr in EXEC and capture dmem_rdata in MEM; dmem_we stays 0.
REQ-026 OUT SHALL update stdout and pulse out_valid in the cycle after EXEC; stdout holds its value otherwise.
REQ-027 In EXEC, PC SHALL become PC+1, wrapping from 2^PROG_AW-1 to 0. JMP and taken JZ instead load the target.
REQ-028 HALT SHALL freeze PC, registers, flags and memory strobes, and hold halted=1.

Reset
REQ-029 While rst=0: state=FETCH, PC=0, IR=0, all registers=0, flags=0, stdout=0, out_valid=0, dmem_we=0, halted=0.
REQ-030 Reset asserted mid-instruction (including during MEM or the STORE cycle) SHALL deassert dmem_we asynchronously and abandon the instruction.
REQ-031 After rst rises, the first FETCH SHALL occur on the first rising clk edge.

Configuration
REQ-032 Macro PROCESSADOR_GEN_BRANCH_EN: when defined, opcode 14 JZ jumps to imm if zero=1 and falls through otherwise. When undefined, opcode 14 executes as NOP and the zero-flag comparator feeding branch logic is omitted; the zero flag itself remains.

Verification
REQ-033 DATA_W=8: MOVI R1,0xF0; MOVI R0,0x20; ADD R1 -> ACC=0x10, carry=1, zero=0.
REQ-034 MOVI R0,5; MOVI R2,5; SUB R2; JZ 0x20 (macro on) -> next prom_addr=0x20. With the macro off -> next prom_addr is PC+1.
REQ-035 MOVI R3,0xAB; STORE R3,0x07; LOAD R1,0x07; OUT R1 -> one dmem_we pulse at addr 7 with data 0xAB, then stdout=0xAB with a single out_valid pulse.
REQ-036 PROG_AW=4, program of 16 NOPs -> PC wraps from 15 to 0, with a 3-cycle instruction period throughout.
REQ-037 Assert rst during the MEM cycle of a LOAD -> target register stays 0, dmem_we=0, and fetch restarts at 0.
REQ-038 NREGS=2: MOVI R5,0x33; OUT R5 -> stdout=0x00 and no register changes; HALT -> halted=1 and PC is frozen for 20 cycles.
